// File: rtl/gb_frame_scaler_if.sv
// Bundle of the PPU pixel stream, the DVI timing request and the TMDS-bound outputs.
// master: PPU/timing side (drives pix_*, gb_*, de/hs/vs_in); slave: the scaler.
// With GB_GRID_EN defined, the bundle also carries gb_grid.
interface gb_frame_scaler_if;
    logic [1:0]  pix_in;
    logic        pix_valid;
    logic        pix_hs;
    logic        pix_vs;
    logic        vsi_out;
    logic [7:0]  gb_x;
    logic [7:0]  gb_y;
    logic        gb_en;
`ifdef GB_GRID_EN
    logic        gb_grid;
`endif
    logic        de_in;
    logic        hs_in;
    logic        vs_in;
    logic [23:0] rgb_out;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;

    modport master (
`ifdef GB_GRID_EN
        output gb_grid,
`endif
        output pix_in, pix_valid, pix_hs, pix_vs,
        output gb_x, gb_y, gb_en, de_in, hs_in, vs_in,
        input  vsi_out, rgb_out, de_out, hs_out, vs_out
    );

    modport slave (
`ifdef GB_GRID_EN
        input  gb_grid,
`endif
        input  pix_in, pix_valid, pix_hs, pix_vs,
        input  gb_x, gb_y, gb_en, de_in, hs_in, vs_in,
        output vsi_out, rgb_out, de_out, hs_out, vs_out
    );
endinterface

// File: rtl/gb_frame_scaler.sv
// Game Boy frame buffer between the PPU pixel stream and the DVI output path.
// Ports: clk, rst (async, active high); bus (gb_frame_scaler_if.slave):
//   PPU side pix_in/pix_valid/pix_hs/pix_vs -> frame buffer, vsi_out restart pulse;
//   DVI side gb_x/gb_y/gb_en/de_in/hs_in/vs_in -> rgb_out/de_out/hs_out/vs_out
//   after a fixed 2-cycle latency.
// Optional macro GB_GRID_EN: adds gb_grid, which halves the colour for a pixel grid.
module gb_frame_scaler #(
    parameter int          GB_W   = 160,
    parameter int          GB_H   = 144,
    parameter logic [23:0] PAL0   = 24'hE0F8D0,
    parameter logic [23:0] PAL1   = 24'h88C070,
    parameter logic [23:0] PAL2   = 24'h346856,
    parameter logic [23:0] PAL3   = 24'h081820,
    parameter logic [23:0] BORDER = 24'h000000
) (
    input logic               clk,
    input logic               rst,
    gb_frame_scaler_if.slave  bus
);

    localparam int         DEPTH = GB_W * GB_H;
    localparam logic [7:0] W8    = 8'(GB_W);
    localparam logic [7:0] H8    = 8'(GB_H);

    function automatic logic [14:0] addr_of(input logic [7:0] x,
                                            input logic [7:0] y);
        logic [14:0] yy;
        yy = {7'd0, y};
        // y*160 as two shifts keeps the default build free of a multiplier.
        if (GB_W == 160)
            return (yy << 7) + (yy << 5) + {7'd0, x};
        else
            return 15'(yy * 15'(GB_W)) + {7'd0, x};
    endfunction

    logic [1:0]  mem [DEPTH];

    // ---------------- write side ----------------
    logic [7:0]  wr_x;
    logic [7:0]  wr_y;
    logic        pvs_q;
    logic        vs_rise;
    logic        wr_ok;
    logic [14:0] wr_addr;

    always_comb begin
        vs_rise = bus.pix_vs & ~pvs_q;
        // A frame-start pixel lands at (0,0) whatever the counters hold.
        wr_ok   = bus.pix_valid & (vs_rise | ((wr_x < W8) && (wr_y < H8)));
        wr_addr = vs_rise ? 15'd0 : addr_of(wr_x, wr_y);
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_addr] <= bus.pix_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_x        <= 8'd0;
            wr_y        <= 8'd0;
            pvs_q       <= 1'b0;
            bus.vsi_out <= 1'b0;
        end else begin
            pvs_q       <= bus.pix_vs;
            bus.vsi_out <= vs_rise;
            if (vs_rise) begin
                wr_y <= 8'd0;
                wr_x <= bus.pix_valid ? 8'd1 : 8'd0;
            end else if (bus.pix_hs) begin
                wr_x <= 8'd0;
                if (wr_y < H8)
                    wr_y <= wr_y + 8'd1;
            end else if (bus.pix_valid && (wr_x < W8)) begin
                wr_x <= wr_x + 8'd1;
            end
        end
    end

    // ---------------- read side, stage 1 ----------------
    logic        in_rng;
    logic [14:0] rd_addr;
    logic [1:0]  rd_q;
    logic        de1;
    logic        hs1;
    logic        vs1;
    logic        rng1;
`ifdef GB_GRID_EN
    logic        grid1;
`endif

    always_comb begin
        in_rng  = bus.gb_en && (bus.gb_x < W8) && (bus.gb_y < H8);
        rd_addr = in_rng ? addr_of(bus.gb_x, bus.gb_y) : 15'd0;
    end

    // Registered read; a same-cycle write to this address returns old data.
    always_ff @(posedge clk) begin
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de1   <= 1'b0;
            hs1   <= 1'b1;
            vs1   <= 1'b1;
            rng1  <= 1'b0;
`ifdef GB_GRID_EN
            grid1 <= 1'b0;
`endif
        end else begin
            de1   <= bus.de_in;
            hs1   <= bus.hs_in;
            vs1   <= bus.vs_in;
            rng1  <= in_rng;
`ifdef GB_GRID_EN
            grid1 <= bus.gb_grid;
`endif
        end
    end

    // ---------------- read side, stage 2 ----------------
    logic [23:0] pal;
    logic [23:0] rgb_d;

    always_comb begin
        case (rd_q)
            2'd0:    pal = PAL0;
            2'd1:    pal = PAL1;
            2'd2:    pal = PAL2;
            default: pal = PAL3;
        endcase
    end

    always_comb begin
        if (!de1)
            rgb_d = 24'd0;
        else if (!rng1)
            rgb_d = BORDER;
        else begin
            rgb_d = pal;
`ifdef GB_GRID_EN
            // Halve each channel; the mask stops bits leaking between bytes.
            if (grid1)
                rgb_d = (pal >> 1) & 24'h7F7F7F;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rgb_out <= 24'd0;
            bus.de_out  <= 1'b0;
            bus.hs_out  <= 1'b1;
            bus.vs_out  <= 1'b1;
        end else begin
            bus.rgb_out <= rgb_d;
            bus.de_out  <= de1;
            bus.hs_out  <= hs1;
            bus.vs_out  <= vs1;
        end
    end

endmodule

// File: tb/tb_gb_frame_scaler.sv
// Scoreboard bench for gb_frame_scaler: stimulus queues expected outputs,
// a negedge monitor compares them on their due cycle.
module tb_gb_frame_scaler;

    localparam logic [23:0] PAL0   = 24'hE0F8D0;
    localparam logic [23:0] PAL1   = 24'h88C070;
    localparam logic [23:0] PAL2   = 24'h346856;
    localparam logic [23:0] PAL3   = 24'h081820;
    localparam logic [23:0] BORDER = 24'h000000;
    localparam logic [27:0] M_VSI  = 28'h8000000;
    localparam logic [27:0] M_VID  = 28'h7FFFFFF;
    localparam logic [27:0] M_ALL  = 28'hFFFFFFF;

    typedef struct {
        int          due;
        string       name;
        logic [27:0] mask;
        logic [27:0] exp;
    } sb_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    sb_t  sb[$];

    gb_frame_scaler_if bus ();

    gb_frame_scaler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor ----------------
    logic [27:0] out_w;
    assign out_w = {bus.vsi_out, bus.rgb_out, bus.de_out,
                    bus.hs_out, bus.vs_out};

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                n_tests++;
                if ((out_w & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %h want %h (mask %h) cycle %0d",
                             sb[i].name, out_w & sb[i].mask,
                             sb[i].exp & sb[i].mask, sb[i].mask, cyc);
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: never sampled, due cycle %0d", sb[i].name,
                         sb[i].due);
                sb.delete(i);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int dly, input string name,
                             input logic [27:0] mask, input logic [27:0] exp);
        sb_t e;
        e.due  = cyc + dly;
        e.name = name;
        e.mask = mask;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic rd(input int x, input int y, input logic en,
                      input logic de, input logic hs, input logic vs,
                      input logic grid, input logic [23:0] rgb,
                      input string name);
        bus.gb_x  = 8'(x);
        bus.gb_y  = 8'(y);
        bus.gb_en = en;
        bus.de_in = de;
        bus.hs_in = hs;
        bus.vs_in = vs;
`ifdef GB_GRID_EN
        bus.gb_grid = grid;
`else
        if (grid) $display("note: grid requested without GB_GRID_EN");
`endif
        expect_at(2, name, M_VID, {1'b0, rgb, de, hs, vs});
        tick();
    endtask

    task automatic idle(input int n);
        bus.pix_valid = 1'b0;
        bus.pix_hs    = 1'b0;
        bus.gb_en     = 1'b0;
        bus.de_in     = 1'b0;
        bus.hs_in     = 1'b1;
        bus.vs_in     = 1'b1;
`ifdef GB_GRID_EN
        bus.gb_grid   = 1'b0;
`endif
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst           = 1'b1;
        bus.pix_in    = 2'd0;
        bus.pix_vs    = 1'b0;
        bus.gb_x      = 8'd0;
        bus.gb_y      = 8'd0;
        idle(3);
        expect_at(0, "reset_in", M_ALL, {1'b0, 24'd0, 1'b0, 1'b1, 1'b1});
        tick();
        rst = 1'b0;
        idle(3);
        expect_at(0, "reset_rel", M_ALL, {1'b0, 24'd0, 1'b0, 1'b1, 1'b1});
        tick();

        // frame start pulse, then pix_vs held high
        bus.pix_vs = 1'b1;
        expect_at(1, "vsi_pulse", M_VSI, {1'b1, 27'd0});
        expect_at(2, "vsi_end", M_VSI, 28'd0);
        expect_at(3, "vsi_hold1", M_VSI, 28'd0);
        expect_at(5, "vsi_hold2", M_VSI, 28'd0);
        tick();
        idle(6);

        // full frame, shade=(x+y)&3; line end shares the last pixel's cycle
        for (int y = 0; y < 144; y++) begin
            for (int x = 0; x < 160; x++) begin
                bus.pix_in    = 2'((x + y) & 3);
                bus.pix_valid = 1'b1;
                bus.pix_hs    = (x == 159);
                tick();
            end
        end
        idle(2);

        rd(5, 2, 1, 1, 1, 1, 0, PAL3, "rd_5_2");
        rd(159, 143, 1, 1, 1, 1, 0, PAL2, "rd_159_143");
        rd(0, 0, 1, 1, 1, 1, 0, PAL0, "rd_0_0");
        rd(1, 0, 1, 1, 1, 1, 0, PAL1, "rd_1_0");
        rd(10, 10, 0, 1, 1, 1, 0, BORDER, "border_en0");
        rd(160, 0, 1, 1, 1, 1, 0, BORDER, "border_x");
        rd(0, 144, 1, 1, 1, 1, 0, BORDER, "border_y");
        rd(5, 2, 1, 0, 1, 1, 0, 24'd0, "de_off");
        rd(5, 2, 1, 1, 0, 1, 0, PAL3, "hs_toggle");
        rd(5, 2, 1, 1, 1, 0, 0, PAL3, "vs_toggle");
        rd(5, 2, 1, 1, 0, 0, 0, PAL3, "hsvs_low");
`ifdef GB_GRID_EN
        rd(0, 0, 1, 1, 1, 1, 1, 24'h707C68, "grid_pal0");
        rd(1, 0, 1, 1, 1, 1, 1, 24'h446038, "grid_pal1");
        rd(10, 10, 0, 1, 1, 1, 1, BORDER, "grid_border");
`else
        rd(0, 0, 1, 1, 1, 1, 0, PAL0, "nogrid_pal0");
`endif
        idle(3);

        // new frame: the edge cycle carries pixel (0,0), 170 pixels on line 0
        bus.pix_vs = 1'b0;
        tick();
        bus.pix_vs    = 1'b1;
        bus.pix_in    = 2'd0;
        bus.pix_valid = 1'b1;
        expect_at(1, "vsi_pulse2", M_VSI, {1'b1, 27'd0});
        expect_at(2, "vsi_end2", M_VSI, 28'd0);
        tick();
        repeat (169) tick();
        bus.pix_valid = 1'b0;
        bus.pix_hs    = 1'b1;
        tick();
        idle(2);

        rd(5, 0, 1, 1, 1, 1, 0, PAL0, "ovf_line0_5");
        rd(159, 0, 1, 1, 1, 1, 0, PAL0, "ovf_line0_159");
        rd(0, 1, 1, 1, 1, 1, 0, PAL1, "ovf_line1_0");
        rd(9, 1, 1, 1, 1, 1, 0, PAL2, "ovf_line1_9");
        idle(3);

        // line saturation: writes past the last line are dropped
        bus.pix_hs = 1'b1;
        repeat (150) tick();
        bus.pix_hs    = 1'b0;
        bus.pix_in    = 2'd0;
        bus.pix_valid = 1'b1;
        repeat (20) tick();
        idle(2);
        rd(0, 143, 1, 1, 1, 1, 0, PAL3, "sat_0_143");
        rd(19, 143, 1, 1, 1, 1, 0, PAL2, "sat_19_143");
        idle(3);

        // reset mid-frame: next pixel goes to (0,0)
        rst = 1'b1;
        tick();
        expect_at(0, "reset_mid", M_ALL, {1'b0, 24'd0, 1'b0, 1'b1, 1'b1});
        tick();
        rst = 1'b0;
        tick();
        bus.pix_in    = 2'd2;
        bus.pix_valid = 1'b1;
        tick();
        idle(2);
        rd(0, 0, 1, 1, 1, 1, 0, PAL2, "post_rst_0_0");
        rd(1, 0, 1, 1, 1, 1, 0, PAL0, "post_rst_1_0");
        idle(1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        while (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: not checked before timeout", sb[0].name);
            void'(sb.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gb_frame_scaler.md
Name: gb_frame_scaler

Overview:
- Bridges the Game Boy PPU pixel stream to the DVI output path.
- Stores one 160x144 frame of 2-bit shades in an on-chip frame buffer, written from the PPU side.
- The read side is addressed by the DVI timing generator's gb_x/gb_y/gb_en/enable signals. It produces registered 24-bit RGB plus delayed sync and data-enable for the TMDS encoder.
- Also produces the vsi resynchronisation pulse that restarts the DVI timing generator on each GB frame start.

Parameters:
- GB_W, 160, GB frame width in pixels.
- GB_H, 144, GB frame height in lines.
- PAL0, 24'hE0F8D0, RGB for shade 0.
- PAL1, 24'h88C070, RGB for shade 1.
- PAL2, 24'h346856, RGB for shade 2.
- PAL3, 24'h081820, RGB for shade 3.
- BORDER, 24'h000000, RGB for active DVI area outside the GB window.

Ports:
- clk  in  1  system clock (PPU and DVI sides share it; both use qualifying strobes)
- rst  in  1  asynchronous, active-high reset
- pix_in  in  2  PPU pixel shade
- pix_valid  in  1  pix_in is valid this cycle
- pix_hs  in  1  PPU end-of-line strobe
- pix_vs  in  1  PPU vertical sync level; rising edge marks frame start
- vsi_out  out  1  one-cycle pulse to the timing generator's vsi input
- gb_x  in  8  GB column requested by timing
- gb_y  in  8  GB row requested by timing
- gb_en  in  1  current DVI pixel lies inside the GB window
- de_in  in  1  DVI active-video enable
- hs_in  in  1  DVI hsync
- vs_in  in  1  DVI vsync
- rgb_out  out  24  pixel colour
- de_out  out  1  de_in delayed
- hs_out  out  1  hs_in delayed
- vs_out  out  1  vs_in delayed

Behaviour:
- Reset values: rgb_out=0, de_out=0, hs_out=1, vs_out=1, vsi_out=0, wr_x=0, wr_y=0, pix_vs history=0. Frame buffer contents are not reset.
- Frame buffer: GB_W*GB_H entries of 2 bits. Address = y*GB_W + x, 15 bits. Inference target is one simple dual-port RAM with a registered read, read-first on a same-address collision (read returns old data).
- Write counters:
  - wr_x ranges 0..GB_W and wr_y ranges 0..GB_H; the value GB_W (resp. GB_H) means overflow.
  - A write happens only when pix_valid=1 and wr_x<GB_W and wr_y<GB_H.
  - pix_valid increments wr_x, saturating at GB_W.
  - pix_hs sets wr_x=0 and increments wr_y, saturating at GB_H.
  - If pix_valid and pix_hs arrive in the same cycle, the pixel is written at the current (wr_x,wr_y) first, then the line advances.
- Frame start:
  - A pix_vs rising edge (pix_vs=1, previous=0) sets wr_y=0.
  - If pix_valid is also 1 that cycle, the pixel is written at (0,0) and wr_x becomes 1; otherwise wr_x becomes 0.
  - vs edge overrides pix_hs in the same cycle.
  - vsi_out=1 in the cycle after the edge, for exactly one cycle.
- Read pipeline, fixed 2-cycle latency from the inputs to all outputs:
  - Stage 1: compute in-range = gb_en && gb_x<GB_W && gb_y<GB_H. Issue the RAM read (address forced to 0 when out of range). Register de_in, hs_in, vs_in and in-range.
  - Stage 2: select the output colour:
    - de=0: rgb_out=0.
    - de=1 and in-range=0: rgb_out=BORDER.
    - Otherwise: palette[shade].
  - Register rgb_out and the delayed de/hs/vs together, so all outputs stay mutually aligned.
- Width rules:
  - y*GB_W is computed as (y<<7)+(y<<5) for the default width; generic multiply is allowed for other widths.
  - No truncation below 15 bits.
- Reset asserted mid-frame: write counters and the pipeline clear immediately. The first write after release goes to (0,0) unless pix_hs arrives first.

Optional Feature:
- GB_GRID_EN adds input gb_grid (1 bit) aligned with gb_en.
- With it defined: gb_grid is pipelined with the other stage-1 signals. When in-range and grid=1, rgb_out = palette colour with each 8-bit channel shifted right by 1, giving the LCD pixel-grid look.
- Without it: the port is absent and colours are unmodified.

Test Plan:
- Reset, then release with all inputs idle -> rgb_out=0, de_out=0, hs_out=1, vs_out=1, vsi_out=0.
- pix_vs rising edge -> vsi_out high for exactly one cycle, one cycle later; holding pix_vs high gives no further pulses.
- Write one frame with shade = (x+y)&3, then read (gb_x=5, gb_y=2, gb_en=1, de_in=1) -> two cycles later rgb_out=PAL3. Read (159,143) -> PAL2.
- Write 170 valid pixels on line 0, then pix_hs -> pixels 160..169 are dropped, line 1 is unaffected. pix_hs 150 times -> wr_y saturates at 144 and further writes are ignored.
- de_in=1 with gb_en=0 -> rgb_out=BORDER. de_in=0 with gb_en=1 -> rgb_out=0. hs_in/vs_in toggles appear on hs_out/vs_out exactly 2 cycles later.
- GB_GRID_EN defined, gb_grid=1 at a PAL0 pixel -> rgb_out=24'h707C68. Same stimulus without the macro -> 24'hE0F8D0.
